// File: rtl/skewed_fifo_bank.sv
// Bank of NUM_CH independent FIFOs with level/overflow tracking and a
// skewed drain engine: channel i starts draining i cycles after channel 0.
module skewed_fifo_bank #(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            wren,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
    output logic [NUM_CH-1:0]            full,
    output logic [NUM_CH-1:0]            empty,
    output logic                         almost_full,
    output logic [NUM_CH*LW-1:0]         level,
    output logic                         overflow,
    input  logic                         clr_err,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_CH-1:0]            rd_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data
);

    localparam int PW = LW - 1;
    localparam int KW = $clog2(NUM_CH);
    localparam logic [KW-1:0] KMAX = KW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d;

    logic [DATA_WIDTH-1:0] mem [NUM_CH][DEPTH];
    logic [PW-1:0]         wptr_q [NUM_CH];
    logic [PW-1:0]         rptr_q [NUM_CH];
    logic [LW-1:0]         lvl_q  [NUM_CH];

    logic [NUM_CH-1:0] wr_ok;
    logic [NUM_CH-1:0] rd_en;
    logic              af;

    // Per-channel status, accepted writes and drain-read enables
    always_comb begin
        wr_ok = '0;
        rd_en = '0;
        full  = '0;
        empty = '0;
        af    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]  = (lvl_q[c] == LW'(DEPTH));
            empty[c] = (lvl_q[c] == '0);
            wr_ok[c] = wren[c] & ~full[c];
            rd_en[c] = (state_q == RUN) && (int'(k_q) >= c) && !empty[c];
            if (lvl_q[c] >= LW'(AF_LEVEL)) af = 1'b1;
        end
    end

    assign almost_full = af;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lvl
        assign level[g*LW +: LW] = lvl_q[g];
    end

    // Pointers, levels and registered read lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                lvl_q[c]  <= '0;
            end
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_ok[c]) wptr_q[c] <= wptr_q[c] + PW'(1);
                if (rd_en[c]) begin
                    rptr_q[c] <= rptr_q[c] + PW'(1);
                    rd_data[c*DATA_WIDTH +: DATA_WIDTH] <= mem[c][rptr_q[c]];
                end
                lvl_q[c] <= lvl_q[c] + LW'(wr_ok[c]) - LW'(rd_en[c]);
            end
        end
    end

    // Storage array, written on accepted writes only
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_ok[c]) mem[c][wptr_q[c]] <= wdata[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Sticky overflow; a new overflow wins over clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 overflow <= 1'b0;
        else if (|(wren & full))    overflow <= 1'b1;
        else if (clr_err)           overflow <= 1'b0;
    end

    // Drain FSM state and skew counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Drain FSM next-state and outputs
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (k_q != KMAX) k_d = k_q + KW'(1);
                if (k_q == KMAX && &empty) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_skewed_fifo_bank.sv
// Directed bench for skewed_fifo_bank: fill/overflow, skewed drain timing,
// empty drain, same-cycle read/write, start-while-busy and mid-drain reset.
module tb_skewed_fifo_bank;

    localparam int NC = 4;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int LW = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NC-1:0]    wren = '0;
    logic [NC*DW-1:0] wdata = '0;
    logic [NC-1:0]    full;
    logic [NC-1:0]    empty;
    logic             almost_full;
    logic [NC*LW-1:0] level;
    logic             overflow;
    logic             clr_err = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic [NC-1:0]    rd_valid;
    logic [NC*DW-1:0] rd_data;

    int errors = 0;
    int checks = 0;

    skewed_fifo_bank #(
        .NUM_CH(NC), .DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wren(wren), .wdata(wdata),
        .full(full), .empty(empty), .almost_full(almost_full),
        .level(level), .overflow(overflow), .clr_err(clr_err),
        .start(start), .busy(busy), .done(done),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] lvl(input int i);
        return level[i*LW +: LW];
    endfunction

    function automatic logic [DW-1:0] lane(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    logic [NC-1:0] exp_rv [1:8];
    int got;

    initial begin
        // 1. reset
        step();
        step();
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdv", 32'(rd_valid), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_af", 32'(almost_full), 32'h0);
        rst_n = 1'b1;
        step();

        // 2. fill and overflow on channel 0
        for (int n = 0; n < 4; n++) begin
            wren  = 4'b0001;
            wdata = 32'(8'h10 + n);
            step();
            wren = '0;
            chk("fill_lvl0", 32'(lvl(0)), 32'(n + 1));
            chk("fill_af", 32'(almost_full), (n >= 2) ? 32'd1 : 32'd0);
        end
        chk("fill_full", 32'(full), 32'h1);
        wren  = 4'b0001;
        wdata = 32'h14;
        step();
        wren = '0;
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_lvl0", 32'(lvl(0)), 32'd4);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (rd_valid[0]) begin
                chk("drain0_data", 32'(lane(0)), 32'(8'h10 + got));
                got++;
            end
            step();
        end
        chk("drain0_count", 32'(got), 32'd4);
        chk("drain0_done", 32'(done), 32'd1);
        step();
        chk("drain0_empty", 32'(empty), 32'hF);

        // 3. skewed drain
        wren  = 4'hF;
        wdata = 32'h30201000;
        step();
        wdata = 32'h31211101;
        step();
        wren = '0;
        chk("skew_levels", 32'(level), 32'h492);
        exp_rv[1] = 4'h0; exp_rv[2] = 4'h1;
        exp_rv[3] = 4'h3; exp_rv[4] = 4'h6;
        exp_rv[5] = 4'hC; exp_rv[6] = 4'h8;
        exp_rv[7] = 4'h0; exp_rv[8] = 4'h0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            chk("skew_busy", 32'(busy), (t <= 6) ? 32'd1 : 32'd0);
            chk("skew_done", 32'(done), (t == 7) ? 32'd1 : 32'd0);
            chk("skew_rdv", 32'(rd_valid), 32'(exp_rv[t]));
            for (int i = 0; i < NC; i++) begin
                if (exp_rv[t][i])
                    chk("skew_data", 32'(lane(i)), 32'(i * 16 + (t - 2 - i)));
            end
            if (t < 8) step();
        end
        chk("skew_empty", 32'(empty), 32'hF);

        // 4. drain with the bank empty
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            chk("mt_busy", 32'(busy), (t <= 4) ? 32'd1 : 32'd0);
            chk("mt_done", 32'(done), (t == 5) ? 32'd1 : 32'd0);
            chk("mt_rdv", 32'(rd_valid), 32'h0);
            if (t < 6) step();
        end

        // 5. same-cycle read and write on channel 0 during RUN
        wren  = 4'b0001;
        wdata = 32'h50;
        step();
        wdata = 32'h51;
        step();
        wren  = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        wren  = 4'b0001;
        wdata = 32'hAA;
        chk("rw_busy", 32'(busy), 32'd1);
        chk("rw_lvl_t1", 32'(lvl(0)), 32'd2);
        step();
        wren = '0;
        chk("rw_lvl_t2", 32'(lvl(0)), 32'd2);
        chk("rw_rdv_t2", 32'(rd_valid), 32'h1);
        chk("rw_data_t2", 32'(lane(0)), 32'h50);
        step();
        chk("rw_rdv_t3", 32'(rd_valid), 32'h1);
        chk("rw_data_t3", 32'(lane(0)), 32'h51);
        chk("rw_lvl_t3", 32'(lvl(0)), 32'd1);
        step();
        chk("rw_rdv_t4", 32'(rd_valid), 32'h1);
        chk("rw_data_t4", 32'(lane(0)), 32'hAA);
        chk("rw_lvl_t4", 32'(lvl(0)), 32'd0);
        chk("rw_done_t4", 32'(done), 32'd0);
        step();
        chk("rw_done_t5", 32'(done), 32'd1);
        chk("rw_rdv_t5", 32'(rd_valid), 32'h0);
        chk("rw_hold_t5", 32'(lane(0)), 32'hAA);
        step();
        chk("rw_done_t6", 32'(done), 32'd0);

        // 6. start while busy is ignored, then reset mid-drain
        for (int n = 0; n < 4; n++) begin
            wren  = 4'b1000;
            wdata = {8'(8'h60 + n), 24'h0};
            step();
        end
        wren = '0;
        chk("rb_full3", 32'(full), 32'h8);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rb_busy_t3", 32'(busy), 32'd1);
        step();
        chk("rb_rdv_t4", 32'(rd_valid), 32'h0);
        step();
        chk("rb_rdv_t5", 32'(rd_valid), 32'h8);
        chk("rb_data_t5", 32'(lane(3)), 32'h60);
        step();
        chk("rb_rdv_t6", 32'(rd_valid), 32'h8);
        chk("rb_data_t6", 32'(lane(3)), 32'h61);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_rdv", 32'(rd_valid), 32'h0);
        chk("ar_level", 32'(level), 32'h0);
        chk("ar_empty", 32'(empty), 32'hF);
        chk("ar_rdata", rd_data, 32'h0);
        step();
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            step();
            chk("ar_nodone", 32'(done), 32'd0);
            chk("ar_idle", 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
